// File: rtl/msi_coherence_ctrl.sv
// -----------------------------------------------------------------------------
// msi_coherence_ctrl
//
// Tag/state directory and MSI coherence controller for an N-way
// set-associative L1. The data array lives elsewhere; this block only tracks
// which lines are present and in which MSI state. It sequences the bus and
// memory handshakes for misses, upgrades and victim writebacks.
//
// Ports:
//   clk, reset_n           clock (rising edge), asynchronous active-low reset
//   cpu_rd, cpu_wr         CPU request, held until cpu_ready (write wins)
//   cpu_addr               CPU request address
//   cpu_ready              one-cycle completion pulse
//   cpu_hit, cpu_way       qualified by cpu_ready: hit/upgrade flag, way used
//   bus_req, bus_cmd       bus transaction request (01 Rd, 10 RdX, 11 Upgr)
//   bus_addr, bus_gnt      line address of the request, grant
//   mem_wb, mem_addr       victim writeback request and victim line address
//   ready_mem              memory completion (writeback done / fill done)
//   snoop_valid/cmd/addr   foreign bus transaction observed this cycle
//   snoop_hit, snoop_flush registered snoop result (line valid / line was M)
//
// Optional build macro MSI_STATS_EN adds saturating 16-bit counters
// hit_cnt, miss_cnt and wb_cnt as extra outputs.
// -----------------------------------------------------------------------------
module msi_coherence_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int OFFSET_W = 2,
  parameter int SET_W    = 5,
  parameter int WAYS     = 2,
  parameter int WAY_W    = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ready,
  output logic              cpu_hit,
  output logic [WAY_W-1:0]  cpu_way,
  output logic              bus_req,
  output logic [1:0]        bus_cmd,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_gnt,
  output logic              mem_wb,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              ready_mem,
  input  logic              snoop_valid,
  input  logic [1:0]        snoop_cmd,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              snoop_hit,
  output logic              snoop_flush
`ifdef MSI_STATS_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt,
  output logic [15:0]       wb_cnt
`endif
);

  localparam int TAG_W = ADDR_W - SET_W - OFFSET_W;
  localparam int SETS  = 1 << SET_W;

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b10;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_RD   = 2'b01;
  localparam logic [1:0] CMD_RDX  = 2'b10;
  localparam logic [1:0] CMD_UPGR = 2'b11;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, BUS, FILL} fsm_e;

  // Next state of a line held here when a foreign transaction hits it.
  function automatic logic [1:0] snoop_next(input logic [1:0] st, input logic [1:0] cmd);
    logic [1:0] nx;
    nx = st;
    if (st == ST_M && cmd == CMD_RD)                          nx = ST_S;
    if (st == ST_M && cmd == CMD_RDX)                         nx = ST_I;
    if (st == ST_S && (cmd == CMD_RDX || cmd == CMD_UPGR))    nx = ST_I;
    return nx;
  endfunction

  function automatic logic snoop_flushes(input logic [1:0] st, input logic [1:0] cmd);
    return (st == ST_M) && (cmd == CMD_RD || cmd == CMD_RDX);
  endfunction

  // Directory and control state
  logic [TAG_W-1:0] dir_tag_q [SETS][WAYS];
  logic [1:0]       dir_st_q  [SETS][WAYS];
  logic [WAY_W-1:0] rr_q      [SETS];

  fsm_e             state_q, state_d;
  logic [TAG_W-1:0] tag_q;
  logic [SET_W-1:0] set_q;
  logic             wr_q;
  logic [WAY_W-1:0] way_q, way_d;
  logic [1:0]       cmd_q, cmd_d;
  logic             cpu_ready_q, cpu_ready_d;
  logic             cpu_hit_q, cpu_hit_d;
  logic [WAY_W-1:0] cpu_way_q, cpu_way_d;
  logic             snoop_hit_q, snoop_flush_q;

  // Local directory write (install, upgrade, victim invalidate)
  logic             lw_en;
  logic [TAG_W-1:0] lw_tag;
  logic [1:0]       lw_st;
  logic             rr_inc;

  logic unused_offsets;
  assign unused_offsets = ^{cpu_addr[OFFSET_W-1:0], snoop_addr[OFFSET_W-1:0]};

  // Lookup: compare the latched request against every way of its set
  logic             hit_any, has_inv;
  logic [WAY_W-1:0] hit_way, inv_way, victim;
  logic [1:0]       hit_st, vict_st;

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    hit_st  = ST_I;
    has_inv = 1'b0;
    inv_way = '0;
    // Descending scan so the lowest-numbered matching way is the one kept.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (dir_st_q[set_q][w] != ST_I && dir_tag_q[set_q][w] == tag_q) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
        hit_st  = dir_st_q[set_q][w];
      end
      if (dir_st_q[set_q][w] == ST_I) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  assign victim  = has_inv ? inv_way : rr_q[set_q];
  assign vict_st = dir_st_q[set_q][victim];

  // Snoop: same compare against the foreign address
  logic [SET_W-1:0] snp_set;
  logic [TAG_W-1:0] snp_tag;
  logic             snp_active, snp_match, snp_hit;
  logic [WAY_W-1:0] snp_way;
  logic [1:0]       snp_st;

  assign snp_set    = snoop_addr[OFFSET_W +: SET_W];
  assign snp_tag    = snoop_addr[ADDR_W-1 -: TAG_W];
  assign snp_active = snoop_valid && (snoop_cmd != CMD_NONE);

  always_comb begin
    snp_match = 1'b0;
    snp_way   = '0;
    snp_st    = ST_I;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (dir_st_q[snp_set][w] != ST_I && dir_tag_q[snp_set][w] == snp_tag) begin
        snp_match = 1'b1;
        snp_way   = WAY_W'(w);
        snp_st    = dir_st_q[snp_set][w];
      end
    end
  end

  assign snp_hit = snp_active && snp_match;

  // A snoop to the very line being looked up delays classification by a
  // cycle so the hit decision always sees the post-snoop state.
  logic lk_stall;
  assign lk_stall = snp_active && (snp_set == set_q) && (snp_tag == tag_q);

  // A foreign RdX/Upgr on the line we hold in S kills our pending upgrade.
  logic upgr_lost;
  assign upgr_lost = snp_hit && (snp_set == set_q) && (snp_way == way_q) &&
                     (snoop_cmd == CMD_RDX || snoop_cmd == CMD_UPGR);

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    way_d       = way_q;
    cpu_ready_d = 1'b0;
    cpu_hit_d   = 1'b0;
    cpu_way_d   = '0;
    lw_en       = 1'b0;
    lw_tag      = tag_q;
    lw_st       = ST_I;
    rr_inc      = 1'b0;
    case (state_q)
      IDLE: begin
        // The request is still high during the completion pulse cycle.
        if ((cpu_rd || cpu_wr) && !cpu_ready_q) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (!lk_stall) begin
          if (hit_any && (!wr_q || hit_st == ST_M)) begin
            cpu_ready_d = 1'b1;
            cpu_hit_d   = 1'b1;
            cpu_way_d   = hit_way;
            state_d     = IDLE;
          end else if (hit_any) begin
            cmd_d   = CMD_UPGR;
            way_d   = hit_way;
            state_d = BUS;
          end else begin
            way_d  = victim;
            rr_inc = !has_inv;
            if (vict_st == ST_M) begin
              state_d = WB;
            end else begin
              cmd_d   = wr_q ? CMD_RDX : CMD_RD;
              state_d = BUS;
            end
          end
        end
      end
      WB: begin
        if (ready_mem) begin
          lw_en   = 1'b1;
          lw_tag  = dir_tag_q[set_q][way_q];
          lw_st   = ST_I;
          cmd_d   = wr_q ? CMD_RDX : CMD_RD;
          state_d = BUS;
        end
      end
      BUS: begin
        if (cmd_q == CMD_UPGR && upgr_lost) begin
          cmd_d = CMD_RDX;
        end else if (bus_gnt) begin
          if (cmd_q == CMD_UPGR) begin
            lw_en       = 1'b1;
            lw_st       = ST_M;
            cpu_ready_d = 1'b1;
            cpu_hit_d   = 1'b1;
            cpu_way_d   = way_q;
            state_d     = IDLE;
          end else begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (ready_mem) begin
          lw_en       = 1'b1;
          lw_st       = wr_q ? ST_M : ST_S;
          cpu_ready_d = 1'b1;
          cpu_way_d   = way_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      tag_q         <= '0;
      set_q         <= '0;
      wr_q          <= 1'b0;
      way_q         <= '0;
      cmd_q         <= CMD_NONE;
      cpu_ready_q   <= 1'b0;
      cpu_hit_q     <= 1'b0;
      cpu_way_q     <= '0;
      snoop_hit_q   <= 1'b0;
      snoop_flush_q <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          dir_tag_q[s][w] <= '0;
          dir_st_q[s][w]  <= ST_I;
        end
      end
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      way_q       <= way_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_hit_q   <= cpu_hit_d;
      cpu_way_q   <= cpu_way_d;
      if (state_q == IDLE && state_d == LOOKUP) begin
        tag_q <= cpu_addr[ADDR_W-1 -: TAG_W];
        set_q <= cpu_addr[OFFSET_W +: SET_W];
        wr_q  <= cpu_wr;
      end
      if (rr_inc) rr_q[set_q] <= rr_q[set_q] + 1'b1;
      snoop_hit_q   <= snp_hit;
      snoop_flush_q <= snp_hit && snoop_flushes(snp_st, snoop_cmd);
      if (snp_hit) dir_st_q[snp_set][snp_way] <= snoop_next(snp_st, snoop_cmd);
      // Written after the snoop update: our transaction is later in bus order.
      if (lw_en) begin
        dir_tag_q[set_q][way_q] <= lw_tag;
        dir_st_q[set_q][way_q]  <= lw_st;
      end
    end
  end

  assign cpu_ready   = cpu_ready_q;
  assign cpu_hit     = cpu_hit_q;
  assign cpu_way     = cpu_way_q;
  assign bus_req     = (state_q == BUS);
  assign bus_cmd     = bus_req ? cmd_q : CMD_NONE;
  assign bus_addr    = bus_req ? {tag_q, set_q, {OFFSET_W{1'b0}}} : '0;
  assign mem_wb      = (state_q == WB);
  assign mem_addr    = mem_wb ? {dir_tag_q[set_q][way_q], set_q, {OFFSET_W{1'b0}}} : '0;
  assign snoop_hit   = snoop_hit_q;
  assign snoop_flush = snoop_flush_q;

`ifdef MSI_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;
  logic        miss_ev, wb_ev;

  assign miss_ev = (state_q == LOOKUP) && !lk_stall && !hit_any;
  assign wb_ev   = (state_q == WB) && ready_mem;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (cpu_ready_d && cpu_hit_d) hit_cnt_q  <= sat_inc(hit_cnt_q);
      if (miss_ev)                  miss_cnt_q <= sat_inc(miss_cnt_q);
      if (wb_ev)                    wb_cnt_q   <= sat_inc(wb_cnt_q);
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
  assign wb_cnt   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_msi_coherence_ctrl.sv
// -----------------------------------------------------------------------------
// tb_msi_coherence_ctrl
//
// Directed bench for msi_coherence_ctrl (default parameters, 2 ways).
// Stimulus pushes expected CPU completions, bus requests, writebacks and snoop
// results into queues; a monitor pops and compares them whenever the DUT shows
// the corresponding output. Point checks (reset values, latency, race command)
// are also queued and evaluated by the monitor, which owns the counters.
// -----------------------------------------------------------------------------
module tb_msi_coherence_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_rd, cpu_wr;
  logic [15:0] cpu_addr;
  logic        cpu_ready, cpu_hit;
  logic [0:0]  cpu_way;
  logic        bus_req;
  logic [1:0]  bus_cmd;
  logic [15:0] bus_addr;
  logic        bus_gnt;
  logic        mem_wb;
  logic [15:0] mem_addr;
  logic        ready_mem;
  logic        snoop_valid;
  logic [1:0]  snoop_cmd;
  logic [15:0] snoop_addr;
  logic        snoop_hit, snoop_flush;

  always #5 clk = ~clk;

  msi_coherence_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_ready(cpu_ready), .cpu_hit(cpu_hit), .cpu_way(cpu_way),
    .bus_req(bus_req), .bus_cmd(bus_cmd), .bus_addr(bus_addr), .bus_gnt(bus_gnt),
    .mem_wb(mem_wb), .mem_addr(mem_addr), .ready_mem(ready_mem),
    .snoop_valid(snoop_valid), .snoop_cmd(snoop_cmd), .snoop_addr(snoop_addr),
    .snoop_hit(snoop_hit), .snoop_flush(snoop_flush)
  );

  // Expected-response queues
  logic [1:0]  exp_cpu [$];   // {hit, way}
  logic [17:0] exp_bus [$];   // {cmd, addr}
  logic [15:0] exp_wb  [$];   // victim address
  logic [1:0]  exp_snp [$];   // {hit, flush}
  string       dq_name [$];
  logic [31:0] dq_act  [$];
  logic [31:0] dq_exp  [$];

  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;

  // Bus/memory responder: automatic mode or manual pass-through
  bit auto_en = 1'b1;
  bit man_gnt = 1'b0;
  bit man_rdy = 1'b0;
  bit fill_pend = 1'b0;

  initial begin
    bus_gnt = 1'b0;
    ready_mem = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!auto_en) begin
        fill_pend = 1'b0;
        bus_gnt   = man_gnt;
        ready_mem = man_rdy;
      end else begin
        bus_gnt   = 1'b0;
        ready_mem = 1'b0;
        if (reset_n !== 1'b1) begin
          fill_pend = 1'b0;
        end else if (bus_req) begin
          bus_gnt   = 1'b1;
          fill_pend = (bus_cmd != 2'b11);
        end else if (mem_wb || fill_pend) begin
          ready_mem = 1'b1;
          fill_pend = 1'b0;
        end
      end
    end
  end

  task automatic push_direct(input string n, input logic [31:0] a, input logic [31:0] e);
    dq_name.push_back(n);
    dq_act.push_back(a);
    dq_exp.push_back(e);
  endtask

  task automatic start_req(input logic wr, input logic [15:0] a);
    @(posedge clk);
    #1;
    cpu_wr   = wr;
    cpu_rd   = !wr;
    cpu_addr = a;
  endtask

  task automatic wait_ready(output int lat);
    bit ok;
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat++;
      if (cpu_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) push_direct("cpu_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
  endtask

  task automatic req(input logic wr, input logic [15:0] a, input logic [1:0] ecpu, input bit chk_lat);
    int lat;
    exp_cpu.push_back(ecpu);
    start_req(wr, a);
    wait_ready(lat);
    if (chk_lat) push_direct("hit_latency", 32'(lat), 32'd3);
  endtask

  task automatic snoop(input logic v, input logic [1:0] cmd, input logic [15:0] a);
    @(posedge clk);
    #1;
    snoop_valid = v;
    snoop_cmd   = cmd;
    snoop_addr  = a;
    @(posedge clk);
    #1;
    snoop_valid = 1'b0;
    snoop_cmd   = 2'b00;
    snoop_addr  = 16'h0;
  endtask

  task automatic wait_high(input string n, input bit sel_wb);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((sel_wb ? mem_wb : bus_req) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) push_direct(n, 32'd0, 32'd1);
  endtask

  // Stimulus
  initial begin
    reset_n = 1'b0;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0;
    snoop_valid = 1'b0; snoop_cmd = 2'b00; snoop_addr = 16'h0;
    #12;
    push_direct("reset_outputs",
                {11'd0, cpu_ready, cpu_hit, cpu_way, bus_req, bus_cmd, (bus_addr != 16'h0),
                 mem_wb, (mem_addr != 16'h0), snoop_hit, snoop_flush}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // 1: read miss then read hit
    exp_bus.push_back({2'b01, 16'h1234});
    req(1'b0, 16'h1234, 2'b00, 1'b0);
    req(1'b0, 16'h1234, 2'b10, 1'b1);

    // 2: write to S line upgrades; next write hits on M
    exp_bus.push_back({2'b11, 16'h1234});
    req(1'b1, 16'h1234, 2'b10, 1'b0);
    req(1'b1, 16'h1234, 2'b10, 1'b1);

    // 3: fill both ways of set 0 in M, then evict way 0 via writeback
    exp_bus.push_back({2'b10, 16'h0080});
    req(1'b1, 16'h0080, 2'b00, 1'b0);
    exp_bus.push_back({2'b10, 16'h1080});
    req(1'b1, 16'h1080, 2'b01, 1'b0);
    exp_wb.push_back(16'h0080);
    exp_bus.push_back({2'b01, 16'h2080});
    req(1'b0, 16'h2080, 2'b00, 1'b0);
    req(1'b0, 16'h2080, 2'b10, 1'b1);
    req(1'b0, 16'h1080, 2'b11, 1'b1);

    // 4: snoops: M+BusRd flushes to S; ignored snoops; S+Upgr invalidates
    exp_snp.push_back(2'b11);
    snoop(1'b1, 2'b01, 16'h1234);
    snoop(1'b1, 2'b00, 16'h1234);
    snoop(1'b0, 2'b10, 16'h1234);
    snoop(1'b1, 2'b01, 16'h5234);
    exp_bus.push_back({2'b11, 16'h1234});
    req(1'b1, 16'h1234, 2'b10, 1'b0);
    exp_snp.push_back(2'b10);
    snoop(1'b1, 2'b11, 16'h2080);
    exp_bus.push_back({2'b01, 16'h2080});
    req(1'b0, 16'h2080, 2'b00, 1'b0);

    // 5: pending upgrade loses its line to a foreign BusRdX
    exp_snp.push_back(2'b11);
    snoop(1'b1, 2'b01, 16'h1234);
    auto_en = 1'b0;
    exp_bus.push_back({2'b11, 16'h1234});
    exp_bus.push_back({2'b10, 16'h1234});
    exp_cpu.push_back(2'b00);
    start_req(1'b1, 16'h1234);
    wait_high("bus_req_timeout", 1'b0);
    exp_snp.push_back(2'b10);
    @(posedge clk);
    #1;
    snoop_valid = 1'b1; snoop_cmd = 2'b10; snoop_addr = 16'h1234;
    @(posedge clk);
    #1;
    snoop_valid = 1'b0; snoop_cmd = 2'b00; snoop_addr = 16'h0;
    push_direct("race_bus_cmd", {30'd0, bus_cmd}, 32'd2);
    man_gnt = 1'b1;
    @(posedge clk);
    #1;
    man_gnt = 1'b0;
    man_rdy = 1'b1;
    @(posedge clk);
    #1;
    man_rdy = 1'b0;
    begin
      int lat;
      wait_ready(lat);
    end
    auto_en = 1'b1;
    req(1'b1, 16'h1234, 2'b10, 1'b1);

    // 6: reset in the middle of a writeback of 0x1080 (way 1, round-robin)
    auto_en = 1'b0;
    exp_wb.push_back(16'h1080);
    start_req(1'b0, 16'h3080);
    wait_high("mem_wb_timeout", 1'b1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    cpu_rd  = 1'b0;
    #1;
    push_direct("reset_abort", {30'd0, mem_wb, bus_req}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    auto_en = 1'b1;
    exp_bus.push_back({2'b01, 16'h0080});
    req(1'b0, 16'h0080, 2'b00, 1'b0);

    repeat (5) @(posedge clk);
    done = 1'b1;
  end

  // Monitor / scoreboard
  initial begin
    logic        prev_req, prev_wb;
    logic [1:0]  prev_cmd;
    logic [15:0] prev_addr;
    logic [1:0]  e2;
    logic [17:0] e18;
    logic [15:0] e16;
    int          cycles;
    prev_req = 1'b0; prev_wb = 1'b0; prev_cmd = 2'b00; prev_addr = 16'h0;
    cycles = 0;
    forever begin
      @(negedge clk);
      cycles++;
      while (dq_name.size() > 0) begin
        string n;
        logic [31:0] a, e;
        n = dq_name.pop_front();
        a = dq_act.pop_front();
        e = dq_exp.pop_front();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
      end
      if (reset_n !== 1'b1) begin
        prev_req = 1'b0; prev_wb = 1'b0; prev_cmd = 2'b00; prev_addr = 16'h0;
      end else begin
        if (cpu_ready === 1'b1) begin
          checks++;
          if (exp_cpu.size() == 0) begin
            errors++;
            $display("FAIL cpu_unexpected: got hit=%0b way=%0d expected no completion", cpu_hit, cpu_way);
          end else begin
            e2 = exp_cpu.pop_front();
            if ({cpu_hit, cpu_way} !== e2) begin
              errors++;
              $display("FAIL cpu_done: got hit=%0b way=%0d expected hit=%0b way=%0d",
                       cpu_hit, cpu_way, e2[1], e2[0]);
            end
          end
        end
        if (bus_req === 1'b1 && (!prev_req || bus_cmd != prev_cmd || bus_addr != prev_addr)) begin
          checks++;
          if (exp_bus.size() == 0) begin
            errors++;
            $display("FAIL bus_unexpected: got cmd=%0b addr=%h expected no bus request", bus_cmd, bus_addr);
          end else begin
            e18 = exp_bus.pop_front();
            if ({bus_cmd, bus_addr} !== e18) begin
              errors++;
              $display("FAIL bus_req: got cmd=%0b addr=%h expected cmd=%0b addr=%h",
                       bus_cmd, bus_addr, e18[17:16], e18[15:0]);
            end
          end
        end
        if (mem_wb === 1'b1 && !prev_wb) begin
          checks++;
          if (exp_wb.size() == 0) begin
            errors++;
            $display("FAIL wb_unexpected: got addr=%h expected no writeback", mem_addr);
          end else begin
            e16 = exp_wb.pop_front();
            if (mem_addr !== e16) begin
              errors++;
              $display("FAIL mem_wb: got addr=%h expected addr=%h", mem_addr, e16);
            end
          end
        end
        if (snoop_hit === 1'b1 || snoop_flush === 1'b1) begin
          checks++;
          if (exp_snp.size() == 0) begin
            errors++;
            $display("FAIL snoop_unexpected: got hit=%0b flush=%0b expected none", snoop_hit, snoop_flush);
          end else begin
            e2 = exp_snp.pop_front();
            if ({snoop_hit, snoop_flush} !== e2) begin
              errors++;
              $display("FAIL snoop_result: got hit=%0b flush=%0b expected hit=%0b flush=%0b",
                       snoop_hit, snoop_flush, e2[1], e2[0]);
            end
          end
        end
        prev_req  = bus_req;
        prev_wb   = mem_wb;
        prev_cmd  = bus_cmd;
        prev_addr = bus_addr;
      end
      if (done) begin
        checks++;
        if (exp_cpu.size() + exp_bus.size() + exp_wb.size() + exp_snp.size() != 0) begin
          errors++;
          $display("FAIL leftover_expected: got cpu=%0d bus=%0d wb=%0d snoop=%0d pending expected 0",
                   exp_cpu.size(), exp_bus.size(), exp_wb.size(), exp_snp.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
      if (cycles > 20000) begin
        checks++;
        errors++;
        $display("FAIL watchdog: got %0d cycles expected completion", cycles);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

endmodule

// File: doc/msi_coherence_ctrl.md
Name: msi_coherence_ctrl

Overview:
Parametrised MSI coherence controller for an N-way set-associative L1: holds the per-line tag and MSI state directory, not the data array.
- Classifies CPU requests as read/write hit/miss in a registered lookup stage.
- Drives writebacks and bus transactions (BusRd, BusRdX, BusUpgr) with grant and memory-ready handshakes.
- Applies snooped transactions from other caches every cycle.
- Sits between the processor core / cache data array and the shared bus, replacing the single-line combinational MSI next-state logic.

Parameters:
ADDR_W, 16, CPU/bus address width
OFFSET_W, 2, line offset bits (ignored for coherence)
SET_W, 5, set index bits (2^SET_W sets)
WAYS, 2, associativity; power of two, 2..8
WAY_W, 1, log2(WAYS)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
cpu_rd  in  1  read request; hold until cpu_ready
cpu_wr  in  1  write request; hold until cpu_ready; wins if both asserted
cpu_addr  in  ADDR_W  request address
cpu_ready  out  1  one-cycle pulse: request complete
cpu_hit  out  1  valid with cpu_ready: 1 = completed from lookup or upgrade
cpu_way  out  WAY_W  valid with cpu_ready: way holding the line
bus_req  out  1  bus transaction request
bus_cmd  out  2  01 BusRd, 10 BusRdX, 11 BusUpgr, 00 none
bus_addr  out  ADDR_W  line address (offset bits zero)
bus_gnt  in  1  bus grant, sampled while bus_req=1
mem_wb  out  1  writeback request for a victim line
mem_addr  out  ADDR_W  victim line address
ready_mem  in  1  memory completion (writeback done / fill done)
snoop_valid  in  1  foreign bus transaction present this cycle
snoop_cmd  in  2  encoding as bus_cmd
snoop_addr  in  ADDR_W  foreign line address
snoop_hit  out  1  registered: snooped line was valid here
snoop_flush  out  1  registered one-cycle pulse: snooped line was M; data array must flush

Behaviour:
- States per line: I=00, S=01, M=10.
- Reset (async, reset_n=0):
  - all lines I, all tags 0, per-set round-robin victim pointers 0, FSM IDLE.
  - every output 0.
  - Reset mid-transaction aborts it with no state update.
- FSM states and transitions:
  - IDLE: on cpu_rd|cpu_wr, latch address and op → LOOKUP.
  - LOOKUP (1 cycle): tag compare across all ways of the set.
    - Read hit (S/M), or write hit on M: cpu_ready=1, cpu_hit=1, cpu_way=hit way → IDLE. Latency: request accepted at edge k, cpu_ready high in cycle k+2.
    - Write hit on S: cmd=BusUpgr → BUS.
    - Miss: victim is the lowest-numbered I way, else the set's round-robin way. The round-robin pointer increments, mod WAYS, only when it is used.
      - Victim in M → WB.
      - Otherwise cmd = BusRd (read) / BusRdX (write) → BUS.
  - WB: mem_wb=1, mem_addr={victim tag, set, 0}. Hold until ready_mem=1; then victim ← I → BUS.
  - BUS: bus_req=1, bus_cmd, bus_addr held stable until bus_gnt=1.
    - Upgr on grant: line ← M, cpu_ready=1, cpu_hit=1 → IDLE.
    - Rd/RdX on grant → FILL.
  - FILL: wait ready_mem=1. Then install the tag in the victim way, state S (read) or M (write), cpu_ready=1, cpu_hit=0 → IDLE.
- Snoop handling, every cycle in every FSM state, results registered one cycle:
  - M + BusRd → S, flush.
  - M + BusRdX → I, flush.
  - S + BusRdX or BusUpgr → I.
  - All other combinations unchanged.
  - snoop_hit=1 if the line was S or M.
- Race: a snoop invalidates the line of a pending, ungranted Upgr → bus_cmd switches to BusRdX the next cycle; completion then follows the FILL path, with cpu_hit=0.
- Race: snoop to a line in WB before ready_mem → the snoop update applies; WB still completes.
- Same-cycle snoop update and local install on the same set/way → the local install wins, because the local transaction is later in bus order.
- Snoops with snoop_cmd=00, or snoop_valid=0, are ignored.

Optional Feature:
MSI_STATS_EN:
- Defined: adds outputs hit_cnt, miss_cnt, wb_cnt, each 16 bits, saturating at 0xFFFF, reset to 0.
  - hit_cnt increments on each completion with cpu_hit=1.
  - miss_cnt increments on each miss classified in LOOKUP.
  - wb_cnt increments on each WB completion.
- Undefined: these ports and their counters are absent; all other behaviour is identical.

Test Plan:
1. After reset, cpu_rd at 0x1234 → LOOKUP miss; bus_req=1, cmd=01, addr=0x1234. bus_gnt, then ready_mem → cpu_ready with cpu_hit=0, line S. Repeat the read → cpu_ready 2 cycles after accept, cpu_hit=1, no bus_req.
2. cpu_wr to the now-S line 0x1234 → cmd=11. Grant → cpu_ready with cpu_hit=1 and no ready_mem wait; a later write to 0x1234 hits with no bus activity.
3. WAYS=2: write-miss 0x0080 and 0x1080 (same set, both → M), then read 0x2080 → mem_wb=1, mem_addr=0x0080 (round-robin way 0). ready_mem → cmd=01 for 0x2080; way 0 now tag of 0x2080 in S.
4. Line 0x1234 in M; snoop BusRd 0x1234 → snoop_hit=1 and snoop_flush one-cycle pulse, line S. Next cpu_wr to 0x1234 → cmd=11.
5. Upgr pending on 0x1234 without grant; snoop BusRdX 0x1234 → bus_cmd=10 next cycle. Grant and ready_mem → line M, cpu_hit=0.
6. Assert reset_n=0 during WB → mem_wb=0 and bus_req=0 immediately. After release, read 0x0080 → miss.
